ps2_key_decoder: RTL

//  Receives PS/2 keyboard frames and delivers make codes to the convolution controller on
//  key_pressed/key_flag.

---
 rtl/ps2_pkg.sv | 12 +
 rtl/ps2_input_filter.sv | 37 +++
 rtl/ps2_key_decoder.sv | 98 +++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, PS/2 prefix bytes and controller key codes
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] KEY_1    = 8'h16;
    localparam logic [7:0] KEY_2    = 8'h1E;
    localparam logic [7:0] KEY_3    = 8'h26;
    localparam logic [7:0] KEY_Q    = 8'h15;
    localparam logic [7:0] KEY_W    = 8'h1D;
    localparam logic [7:0] KEY_E    = 8'h24;
endpackage

// File: rtl/ps2_input_filter.sv
// ps2_input_filter: pin synchroniser, ps2_clk glitch filter and falling-edge bit event
module ps2_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic bit_evt,
    output logic data_s
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [SYNC_STAGES-1:0] cs, ds;
    logic [CW-1:0] cnt;
    logic level, raw_c, flip;
    assign raw_c = cs[SYNC_STAGES-1];
    assign flip  = (raw_c != level) && (cnt == CW'(FILTER_LEN - 1));
    // synchronise pins, count consecutive samples away from the filtered level, flag 1->0 flips
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs      <= '1;
            ds      <= '1;
            cnt     <= '0;
            level   <= 1'b1;
            bit_evt <= 1'b0;
            data_s  <= 1'b1;
        end else begin
            cs      <= {cs[SYNC_STAGES-2:0], ps2_clk};
            ds      <= {ds[SYNC_STAGES-2:0], ps2_data};
            cnt     <= (raw_c == level || flip) ? '0 : cnt + 1'b1;
            level   <= flip ? raw_c : level;
            bit_evt <= flip && level;
            data_s  <= ds[SYNC_STAGES-1];
        end
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 frame receiver with parity/stop check, timeout and E0/F0 prefix stripping
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_pressed,
    output logic       key_flag,
    output logic       key_ext,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    ps2_state_t state, state_n;
    logic bit_evt, data_s, tmo_hit, stop_evt, frame_ok;
    logic [2:0] cnt;
    logic [7:0] shreg;
    logic parity, ext_pending, brk_pending;
    logic [TW-1:0] tmo;

    ps2_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filter (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .bit_evt(bit_evt), .data_s(data_s)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state; a bit event always takes precedence over the timeout
    always_comb begin
        state_n  = state;
        tmo_hit  = state != IDLE && tmo == TW'(TIMEOUT_CYCLES - 1) && !bit_evt;
        stop_evt = bit_evt && state == STOP;
        frame_ok = stop_evt && data_s && (^{shreg, parity});
        if (bit_evt) begin
            case (state)
                IDLE:    state_n = data_s ? IDLE : DATA;
                DATA:    state_n = cnt == 3'd7 ? PARITY : DATA;
                PARITY:  state_n = STOP;
                default: state_n = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_n = IDLE;
        end
    end

    // shifter, timeout counter, prefix tracking and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            shreg       <= '0;
            parity      <= 1'b0;
            tmo         <= '0;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
            key_pressed <= 8'h00;
            key_flag    <= 1'b0;
            key_ext     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            tmo       <= (bit_evt || state == IDLE) ? '0 : tmo + 1'b1;
            key_flag  <= 1'b0;
            frame_err <= (stop_evt && !frame_ok) || tmo_hit;
            if (bit_evt && state == IDLE) cnt <= '0;
            if (bit_evt && state == DATA) begin
                shreg <= {data_s, shreg[7:1]};
                cnt   <= cnt + 1'b1;
            end
            if (bit_evt && state == PARITY) parity <= data_s;
            if ((stop_evt && !frame_ok) || tmo_hit) begin
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
            end else if (frame_ok) begin
                if (shreg == SC_EXT) begin
                    ext_pending <= 1'b1;
                end else if (shreg == SC_BREAK) begin
                    brk_pending <= 1'b1;
                end else if (brk_pending) begin
                    ext_pending <= 1'b0;
                    brk_pending <= 1'b0;
                end else begin
                    key_pressed <= shreg;
                    key_ext     <= ext_pending;
                    key_flag    <= 1'b1;
                    ext_pending <= 1'b0;
                end
            end
        end
    end
endmodule
